// File: rtl/muldiv_issue.sv
// Issue/interlock stage in front of the HI/LO multiply/divide unit: one-entry
// request buffer, single-cycle issue pulse, and stalled mfhi/mflo reads.
module muldiv_issue #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [2:0]    IN_OP,
  input  logic [W-1:0]  IN_A,
  input  logic [W-1:0]  IN_B,
  input  logic          FLUSH,
  input  logic          MF_REQ,
  input  logic          MF_SEL,
  output logic          MF_STALL,
  output logic [W-1:0]  MF_DATA,
  output logic          MD_EN,
  output logic [2:0]    MD_OP,
  output logic [W-1:0]  MD_A,
  output logic [W-1:0]  MD_B,
  input  logic          MD_BUSY,
  input  logic [W-1:0]  MD_HI,
  input  logic [W-1:0]  MD_LO,
  output logic          PENDING,
  output logic [CW-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    ISSUED,
    BUSY
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          buf_valid;
  logic          buf_valid_nxt;
  logic [2:0]    buf_op;
  logic [W-1:0]  buf_a;
  logic [W-1:0]  buf_b;
  logic [CW-1:0] stall_cnt;

  logic          guard;
  logic          eff_busy;
  logic          issue_now;
  logic          accept;

  // The unit only shows BUSY one cycle after EN; ISSUED is exactly that gap.
  assign guard     = (state == ISSUED);
  assign eff_busy  = MD_BUSY | guard;
  assign issue_now = buf_valid & ~eff_busy & ~FLUSH;
  assign accept    = IN_VALID & IN_READY;

  assign IN_READY  = ~buf_valid | issue_now;
  assign MD_EN     = issue_now;
  assign MD_OP     = buf_op;
  assign MD_A      = buf_a;
  assign MD_B      = buf_b;
  assign PENDING   = buf_valid | eff_busy;
  assign STALL_CNT = stall_cnt;

  // Reads see the state before this cycle's accept: the read is the older op.
  assign MF_STALL  = MF_REQ & (buf_valid | eff_busy);
  assign MF_DATA   = MF_REQ ? (MF_SEL ? MD_HI : MD_LO) : '0;

  // FLUSH wins over a same-cycle accept, so that request is dropped too.
  always_comb begin
    buf_valid_nxt = buf_valid;
    if (FLUSH) begin
      buf_valid_nxt = 1'b0;
    end else if (accept) begin
      buf_valid_nxt = 1'b1;
    end else if (issue_now) begin
      buf_valid_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MD_BUSY)            state_nxt = BUSY;
        else if (buf_valid_nxt) state_nxt = HELD;
      end
      HELD: begin
        if (issue_now)           state_nxt = ISSUED;
        else if (MD_BUSY)        state_nxt = BUSY;
        else if (!buf_valid_nxt) state_nxt = IDLE;
      end
      ISSUED: begin
        if (MD_BUSY)            state_nxt = BUSY;
        else if (buf_valid_nxt) state_nxt = HELD;
        else                    state_nxt = IDLE;
      end
      BUSY: begin
        if (!MD_BUSY) begin
          if (issue_now)          state_nxt = ISSUED;
          else if (buf_valid_nxt) state_nxt = HELD;
          else                    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; combinational
  // decode above lives in always_comb with a default assigned first.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      buf_valid <= buf_valid_nxt;
    end
  end

  // NOTE: the payload registers are reset even though buf_valid qualifies
  // them, because they drive MD_OP/MD_A/MD_B directly and must read 0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      buf_op <= '0;
      buf_a  <= '0;
      buf_b  <= '0;
    end else if (accept && !FLUSH) begin
      buf_op <= IN_OP;
      buf_a  <= IN_A;
      buf_b  <= IN_B;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
    end else if (MF_STALL && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule
